// File: rtl/mul_div_unit.sv
// Iterative 32-bit unsigned multiply/divide unit: shift-add MUL/MULHU and
// restoring DIVU/REMU, one bit per cycle, writing its result to the register file.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [4:0]  dest,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        reg_write,
  output logic [4:0]  write_addr
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  dest_q;
  logic [5:0]  cnt;
  logic [63:0] acc, acc_nxt;
  logic [32:0] sum, diff;

  // MUL: acc = {partial product, multiplier}; DIV: acc = {remainder, dividend/quotient}
  always_comb begin
    sum  = {1'b0, acc[63:32]} + {1'b0, a_q};
    diff = acc[63:31] - {1'b0, b_q};
    if (!op_q[1])
      acc_nxt = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
    else if (diff[32])
      acc_nxt = {acc[62:0], 1'b0};
    else
      acc_nxt = {diff[31:0], acc[30:0], 1'b1};
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    reg_write = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        // cnt reaches 32 after the last iteration; that cycle latches the result
        if (cnt[5]) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        reg_write = (dest_q != 5'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign write_addr = dest_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 2'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      dest_q <= 5'd0;
      cnt    <= 6'd0;
      acc    <= 64'd0;
      result <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q   <= op;
          a_q    <= src_a;
          b_q    <= src_b;
          dest_q <= dest;
          cnt    <= 6'd0;
          acc    <= {32'd0, op[1] ? src_a : src_b};
        end
        RUN: begin
          if (!cnt[5]) begin
            acc <= acc_nxt;
            cnt <= cnt + 6'd1;
          end else begin
            result <= op_q[0] ? acc[63:32] : acc[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
